pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS datapath. It holds the architectural PC, computes the next PC for the supported control-flow modes, and stalls on request. It halts cleanly when the next address leaves the legal instruction window or is misaligned, and counts accepted PC updates. It sits at the head of the fetch stage, feeding instruction memory and the PC+4 path to the control and writeback logic.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_unit_if.sv | 30 +++
 rtl/pc_next_calc.sv | 40 ++++
 rtl/pc_unit.sv | 75 +++++++
 tb/tb_pc_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the program-counter unit.
//   - next-PC mode selects (SEL_*)
//   - halt cause codes (HC_*)
//   - FSM state type and state constants
package pc_pkg;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;
    localparam logic [1:0] SEL_JR  = 2'b11;

    localparam logic [1:0] HC_NONE  = 2'b00;
    localparam logic [1:0] HC_LIMIT = 2'b01;
    localparam logic [1:0] HC_ALIGN = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t ST_RUN  = 1'b0;
    localparam state_t ST_HALT = 1'b1;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: request/status bundle between the fetch control and pc_unit.
//   master (requester) drives: stall, sel, branch_taken, imm_off,
//                              jump_target, jr_addr
//   slave  (pc_unit)   drives: pc, pc_plus4, halted, halt_cause, upd_count
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic [1:0]       sel;
    logic             branch_taken;
    logic [WIDTH-1:0] imm_off;
    logic [25:0]      jump_target;
    logic [WIDTH-1:0] jr_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] upd_count;

    modport master (
        output stall, sel, branch_taken, imm_off, jump_target, jr_addr,
        input  pc, pc_plus4, halted, halt_cause, upd_count
    );

    modport slave (
        input  stall, sel, branch_taken, imm_off, jump_target, jr_addr,
        output pc, pc_plus4, halted, halt_cause, upd_count
    );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: purely combinational next-PC mux/adder.
//   in : pc, sel, branch_taken, imm_off, jump_target, jr_addr
//   out: pc_plus4 (pc + 4), nxt (candidate next PC),
//        misaligned (nxt[1:0] != 0), over_limit (nxt >= LIMIT_ADDR)
import pc_pkg::*;

module pc_next_calc #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] LIMIT_ADDR = 32'd32764
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] imm_off,
    input  logic [25:0]      jump_target,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] nxt,
    output logic             misaligned,
    output logic             over_limit
);

    assign pc_plus4 = pc + WIDTH'(4);

    // All sums wrap modulo 2^WIDTH; wrap is only caught by the checks below.
    always_comb begin
        nxt = pc_plus4;
        case (sel)
            SEL_SEQ: nxt = pc_plus4;
            SEL_BR:  nxt = branch_taken ? (pc_plus4 + (imm_off << 2)) : pc_plus4;
            SEL_J:   nxt = {pc_plus4[WIDTH-1:28], jump_target, 2'b00};
            SEL_JR:  nxt = jr_addr;
            default: nxt = pc_plus4;
        endcase
    end

    assign misaligned = (nxt[1:0] != 2'b00);
    assign over_limit = (nxt >= LIMIT_ADDR);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC register with RUN/HALT FSM and update counter.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : pc_unit_if slave port (stall/sel/operands in; pc, pc_plus4,
//         halted, halt_cause, upd_count out)
// An illegal next PC (misaligned or >= LIMIT_ADDR) is never loaded; the unit
// halts instead and stays halted until reset.
import pc_pkg::*;

module pc_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [WIDTH-1:0] LIMIT_ADDR = 32'd32764,
    parameter int unsigned      CNT_W      = 32
) (
    input logic        clk,
    input logic        rst,
    pc_unit_if.slave   bus
);

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] nxt;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] upd_count;
    logic             misaligned;
    logic             over_limit;

    pc_next_calc #(
        .WIDTH      (WIDTH),
        .LIMIT_ADDR (LIMIT_ADDR)
    ) u_next (
        .pc           (pc),
        .sel          (bus.sel),
        .branch_taken (bus.branch_taken),
        .imm_off      (bus.imm_off),
        .jump_target  (bus.jump_target),
        .jr_addr      (bus.jr_addr),
        .pc_plus4     (pc_plus4),
        .nxt          (nxt),
        .misaligned   (misaligned),
        .over_limit   (over_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            pc         <= RESET_ADDR;
            halt_cause <= HC_NONE;
            upd_count  <= '0;
        end else if (state == ST_RUN && !bus.stall) begin
            // Misalignment is checked first so it wins over the limit.
            if (misaligned) begin
                state      <= ST_HALT;
                halt_cause <= HC_ALIGN;
            end else if (over_limit) begin
                state      <= ST_HALT;
                halt_cause <= HC_LIMIT;
            end else begin
                pc <= nxt;
                if (upd_count != '1) begin
                    upd_count <= upd_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pc         = pc;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.halted     = (state == ST_HALT);
    assign bus.halt_cause = halt_cause;
    assign bus.upd_count  = upd_count;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a
// behavioural reference model (PC, counter, halt flag, halt cause).
module tb_pc_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned CW    = 4;
    localparam int unsigned LIMIT = 32764;
    localparam int unsigned CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [31:0] m_pc;
    int          m_cnt;
    logic        m_halted;
    logic [1:0]  m_cause;

    pc_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    pc_unit #(
        .WIDTH      (W),
        .RESET_ADDR (32'd0),
        .LIMIT_ADDR (32'd32764),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_nxt(input logic [31:0] pc, input logic [1:0] sel,
                                            input logic bt, input logic [31:0] imm,
                                            input logic [25:0] jt, input logic [31:0] jr);
        logic [31:0] p4;
        logic [31:0] jtw;
        p4  = pc + 32'd4;
        jtw = {6'd0, jt};
        case (sel)
            2'd1:    return bt ? p4 + imm * 32'd4 : p4;
            2'd2:    return (p4 & 32'hF000_0000) | (jtw * 32'd4);
            2'd3:    return jr;
            default: return p4;
        endcase
    endfunction

    function automatic logic [70:0] expected();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        return {m_pc, p4, m_halted, m_cause, CW'(m_cnt)};
    endfunction

    function automatic logic [70:0] observed();
        return {bus.pc, bus.pc_plus4, bus.halted, bus.halt_cause, bus.upd_count};
    endfunction

    // One clock: update the model from the inputs seen at the edge, then settle.
    task automatic advance();
        logic [31:0] n;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'd0; m_cnt = 0; m_halted = 1'b0; m_cause = 2'd0;
        end else if (!m_halted && !bus.stall) begin
            n = ref_nxt(m_pc, bus.sel, bus.branch_taken, bus.imm_off, bus.jump_target, bus.jr_addr);
            if (n % 4 != 0) begin
                m_halted = 1'b1; m_cause = 2'd2;
            end else if (n >= LIMIT) begin
                m_halted = 1'b1; m_cause = 2'd1;
            end else begin
                m_pc = n;
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic stall, input logic [1:0] sel, input logic bt,
                         input logic [31:0] imm, input logic [25:0] jt, input logic [31:0] jr);
        bus.stall = stall; bus.sel = sel; bus.branch_taken = bt;
        bus.imm_off = imm; bus.jump_target = jt; bus.jr_addr = jr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0);
        do_reset();
        checks++;
        if (observed() !== {32'd0, 32'd4, 1'b0, 2'd0, 4'd0}) begin
            errors++; $display("FAIL reset_state: got %h want %h", observed(), {32'd0, 32'd4, 1'b0, 2'd0, 4'd0});
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0);
            advance();
            checks++;
            if (bus.pc !== 32'(4 * i)) begin
                errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, 32'(4 * i));
            end
        end
        checks++;
        if (bus.upd_count !== 4'd4 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL seq_count: got cnt=%0d halted=%b want cnt=4 halted=0", bus.upd_count, bus.halted);
        end
    endtask

    task automatic test_branch();
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h100); advance();
        drive(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'd0); advance();
        checks++;
        if (bus.pc !== 32'hFC) begin
            errors++; $display("FAIL branch_taken: got %h want %h", bus.pc, 32'hFC);
        end
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h100); advance();
        drive(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFE, 26'd0, 32'd0); advance();
        checks++;
        if (bus.pc !== 32'h104) begin
            errors++; $display("FAIL branch_not_taken: got %h want %h", bus.pc, 32'h104);
        end
    endtask

    task automatic test_jump();
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h40); advance();
        drive(1'b0, 2'd2, 1'b0, 32'd0, 26'h20, 32'd0); advance();
        checks++;
        if (bus.pc !== 32'h80) begin
            errors++; $display("FAIL jump: got %h want %h", bus.pc, 32'h80);
        end
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h200); advance();
        checks++;
        if (bus.pc !== 32'h200 || bus.pc_plus4 !== 32'h204) begin
            errors++; $display("FAIL jump_reg: got pc=%h p4=%h want pc=200 p4=204", bus.pc, bus.pc_plus4);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0;
        logic [3:0]  c0;
        pc0 = bus.pc; c0 = bus.upd_count;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 1'b0, 32'd0, 26'd0, 32'h300); advance();
            checks++;
            if (bus.pc !== pc0 || bus.upd_count !== c0 || observed() !== expected()) begin
                errors++; $display("FAIL stall_hold[%0d]: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, bus.pc, bus.upd_count, pc0, c0);
            end
        end
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h300); advance();
        checks++;
        if (bus.pc !== 32'h300) begin
            errors++; $display("FAIL stall_release: got %h want %h", bus.pc, 32'h300);
        end
        // a stalled illegal target must not halt
        drive(1'b1, 2'd3, 1'b0, 32'd0, 26'd0, 32'h203); advance();
        checks++;
        if (bus.halted !== 1'b0 || bus.pc !== 32'h300) begin
            errors++; $display("FAIL stall_no_check: got halted=%b pc=%h want 0 300", bus.halted, bus.pc);
        end
        // reset during stall with a pending redirect discards it
        rst = 1'b1;
        drive(1'b1, 2'd3, 1'b0, 32'd0, 26'd0, 32'h400); advance();
        rst = 1'b0;
        checks++;
        if (observed() !== {32'd0, 32'd4, 1'b0, 2'd0, 4'd0}) begin
            errors++; $display("FAIL rst_over_stall: got %h want %h", observed(), {32'd0, 32'd4, 1'b0, 2'd0, 4'd0});
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0); advance();
        end
        checks++;
        if (bus.upd_count !== 4'hF || bus.pc !== 32'd80) begin
            errors++; $display("FAIL saturate: got cnt=%0d pc=%h want cnt=15 pc=50", bus.upd_count, bus.pc);
        end
    endtask

    task automatic test_halt();
        logic [3:0] c0;
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h7FF8); advance();
        c0 = bus.upd_count;
        drive(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0); advance();
        checks++;
        if (bus.pc !== 32'h7FF8 || bus.halted !== 1'b1 || bus.halt_cause !== 2'd1 || bus.upd_count !== c0) begin
            errors++; $display("FAIL halt_limit: got pc=%h h=%b c=%0d cnt=%0d want 7ff8 1 1 %0d", bus.pc, bus.halted, bus.halt_cause, bus.upd_count, c0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 2'($urandom), 1'($urandom), 32'd4, 26'd1, 32'h100); advance();
            checks++;
            if (observed() !== {32'h7FF8, 32'h7FFC, 1'b1, 2'd1, c0}) begin
                errors++; $display("FAIL halt_frozen[%0d]: got %h want %h", i, observed(), {32'h7FF8, 32'h7FFC, 1'b1, 2'd1, c0});
            end
        end
        do_reset();
        checks++;
        if (observed() !== {32'd0, 32'd4, 1'b0, 2'd0, 4'd0}) begin
            errors++; $display("FAIL halt_reset: got %h want %h", observed(), {32'd0, 32'd4, 1'b0, 2'd0, 4'd0});
        end
        drive(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0); advance();
        checks++;
        if (bus.pc !== 32'd4 || bus.upd_count !== 4'd1) begin
            errors++; $display("FAIL resume: got pc=%h cnt=%0d want 4 1", bus.pc, bus.upd_count);
        end
        do_reset();
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h202); advance();
        checks++;
        if (bus.pc !== 32'd0 || bus.halted !== 1'b1 || bus.halt_cause !== 2'd2) begin
            errors++; $display("FAIL halt_align: got pc=%h h=%b c=%0d want 0 1 2", bus.pc, bus.halted, bus.halt_cause);
        end
        // misaligned and over the limit at once: alignment wins
        do_reset();
        drive(1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'hFFFF_FFFE); advance();
        checks++;
        if (bus.halted !== 1'b1 || bus.halt_cause !== 2'd2) begin
            errors++; $display("FAIL halt_both: got h=%b c=%0d want 1 2", bus.halted, bus.halt_cause);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] jr;
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) < (m_halted ? 25 : 2));
            jr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 8200)) * 32'd4;
            if ($urandom_range(0, 15) == 0) jr = jr | 32'd2;
            drive($urandom_range(0, 3) == 0, 2'($urandom), 1'($urandom),
                  32'($urandom_range(0, 64)) - 32'd32, 26'($urandom_range(0, 8200)), jr);
            advance();
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, observed(), expected());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_pc = '0; m_cnt = 0; m_halted = 1'b0; m_cause = 2'd0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_saturate();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
